fp_mult_sequencer: RTL and testbench

FP_MULT_SEQUENCER -- requirements
Module: fp_mult_sequencer

---
 rtl/fp_mult_sequencer.sv | 102 ++++++++++
 tb/tb_fp_mult_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_sequencer.sv
// fp_mult_sequencer: issues one operand pair at a time to an external two-stage
// fp_mult and collects its results in an in-order result FIFO.
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_rnd)
//   mul_a/mul_b/mul_rnd         held operands to fp_mult; mul_rst_n = ~rst
//   mul_z/mul_status            fp_mult result, captured at the end of DONE
//   out_valid/out_ready         result handshake (out_z, out_status)
//   busy                        an operation is in flight
//   count                       results held in the FIFO
module fp_mult_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [2:0]               in_rnd,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    output logic [2:0]               mul_rnd,
    output logic                     mul_rst_n,
    input  logic [31:0]              mul_z,
    input  logic [7:0]               mul_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [7:0]               out_status,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DM1 = DEPTH - 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [AW:0] ALMOST = DM1[AW:0];

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]    op_rnd_q, op_rnd_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   z_mem [DEPTH];
    logic [7:0]    st_mem [DEPTH];
    logic          accept, push, pop;

    assign out_valid  = !rst && count_q != '0;
    assign out_z      = z_mem[rd_ptr_q];
    assign out_status = st_mem[rd_ptr_q];
    assign busy       = !rst && state_q != IDLE;
    assign mul_rst_n  = ~rst;
    assign mul_a      = op_a_q;
    assign mul_b      = op_b_q;
    assign mul_rnd    = op_rnd_q;
    assign count      = count_q;

    always_comb begin
        // Accepting in DONE needs two free slots: the current result lands at
        // the same edge the new operation starts, and a pop is not credited.
        in_ready = !rst && ((state_q == IDLE && count_q < FULL) ||
                            (state_q == DONE && count_q < ALMOST));
        accept   = in_valid && in_ready;
        push     = state_q == DONE;
        pop      = out_valid && out_ready;
        state_d  = state_q == EXEC ? DONE : (accept ? EXEC : IDLE);
        op_a_d   = accept ? in_a : op_a_q;
        op_b_d   = accept ? in_b : op_b_q;
        op_rnd_d = accept ? in_rnd : op_rnd_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_rnd_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_rnd_q <= op_rnd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            z_mem[wr_ptr_q]  <= mul_z;
            st_mem[wr_ptr_q] <= mul_status;
        end
    end
endmodule

// File: tb/tb_fp_mult_sequencer.sv
// tb_fp_mult_sequencer: directed vectors, queue scoreboard, count/valid model.
module tb_fp_mult_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, mul_rst_n, out_valid, out_ready, busy;
    logic [31:0] in_a, in_b, mul_a, mul_b, mul_z, out_z;
    logic [2:0]  in_rnd, mul_rnd;
    logic [7:0]  mul_status, out_status;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fp_mult_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd), .mul_rst_n(mul_rst_n),
        .mul_z(mul_z), .mul_status(mul_status),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .busy(busy), .count(count)
    );

    // Hand-computed products: a * b = z with fp_mult status s.
    localparam logic [31:0] VA [8] = '{32'h40000000, 32'h3F800000, 32'h7F800000, 32'h40000000,
                                       32'h3F800000, 32'h40800000, 32'h41000000, 32'h3F000000};
    localparam logic [31:0] VB [8] = '{32'h40400000, 32'h3F800000, 32'h00000000, 32'h40000000,
                                       32'h40400000, 32'h40000000, 32'h40000000, 32'h40800000};
    localparam logic [31:0] VZ [8] = '{32'h40C00000, 32'h3F800000, 32'h7FC00000, 32'h40800000,
                                       32'h40400000, 32'h41000000, 32'h41800000, 32'h40000000};
    localparam logic [7:0]  VS [8] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // fp_mult stand-in: operands registered at each edge, result looked up.
    logic [31:0] p_a, p_b;
    always @(posedge clk) begin
        p_a <= mul_a;
        p_b <= mul_b;
    end
    always_comb begin
        mul_z = 32'hBAD0BAD0;
        mul_status = 8'hFF;
        for (int i = 0; i < 8; i++)
            if (p_a == VA[i] && p_b == VB[i]) begin
                mul_z = VZ[i];
                mul_status = VS[i];
            end
    end

    int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, kk = 0, nacc = 0;
    logic [39:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus a count/out_valid model driven by the handshakes.
    int model_count = 0;
    bit acc_h0 = 0, acc_h1 = 0;
    always @(negedge clk) begin
        logic [39:0] e;
        chk("count", 64'(count), 64'(model_count));
        chk("out_valid", 64'(out_valid), 64'(!rst && model_count != 0));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got z=%h status=%h required none", out_z, out_status);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'({out_z, out_status}), 64'(e));
            end
        end
        if (rst) begin
            model_count = 0;
            acc_h0 = 0;
            acc_h1 = 0;
            exp_q.delete();
        end else begin
            model_count = model_count + int'(acc_h1) - int'(out_valid && out_ready);
            acc_h1 = acc_h0;
            acc_h0 = in_valid && in_ready;
        end
    end

    task automatic offer(input int k, input logic [2:0] r);
        int n = 0;
        in_a = VA[k];
        in_b = VB[k];
        in_rnd = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles required 1", in_ready, n);
        end else begin
            exp_q.push_back({VZ[k], VS[k]});
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic stream(input int ncyc);
        nacc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            in_a = VA[kk % 8];
            in_b = VB[kk % 8];
            in_rnd = 3'd0;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({VZ[kk % 8], VS[kk % 8]});
                kk++;
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, rel;
        in_valid = 0; in_a = 0; in_b = 0; in_rnd = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mul_rst_n", 64'(mul_rst_n), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_mul_rst_n", 64'(mul_rst_n), 64'(1));
        chk("idle_mul_a", 64'(mul_a), 64'(0));
        chk("idle_mul_rnd", 64'(mul_rnd), 64'(0));
        @(posedge clk);
        #1 out_ready = 1;
        // 2.0 * 3.0, result visible exactly three cycles after accept
        offer(0, 3'd0);
        @(negedge clk);
        chk("lat_exec_busy", 64'(busy), 64'(1));
        chk("lat_exec_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_done_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_out_valid", 64'(out_valid), 64'(1));
        drain();
        // back-to-back: 1*1 then inf*0 (NaN, invalid flag)
        offer(1, 3'd0);
        t0 = acc_cyc;
        offer(2, 3'd0);
        chk("b2b_spacing", 64'(acc_cyc - t0), 64'(2));
        drain();
        // operands must stay held while the inputs wander
        offer(3, 3'd5);
        repeat (2) begin
            in_a = $urandom;
            in_b = $urandom;
            in_rnd = 3'($urandom);
            @(negedge clk);
            chk("hold_mul_a", 64'(mul_a), 64'(VA[3]));
            chk("hold_mul_b", 64'(mul_b), 64'(VB[3]));
            chk("hold_mul_rnd", 64'(mul_rnd), 64'(5));
            chk("hold_busy", 64'(busy), 64'(1));
            @(posedge clk);
            #1;
        end
        drain();
        // fill with the consumer stalled
        out_ready = 0;
        kk = 0;
        stream(12);
        chk("fill_accepts", 64'(nacc), 64'(4));
        @(negedge clk);
        chk("full_count", 64'(count), 64'(4));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        stream(12);
        chk("refill_accepts", 64'(nacc), 64'(1));
        @(negedge clk);
        chk("refull_count", 64'(count), 64'(4));
        // full FIFO draining while offers continue
        @(posedge clk);
        #1 out_ready = 1;
        stream(20);
        chk("stream_accepts", 64'(nacc), 64'(10));
        drain();
        // reset pulse during DONE with two results stored
        out_ready = 0;
        offer(4, 3'd0);
        offer(5, 3'd0);
        offer(6, 3'd0);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("pulse_count_before", 64'(count), 64'(2));
        chk("pulse_in_ready", 64'(in_ready), 64'(0));
        chk("pulse_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 rst = 0;
        rel = cyc;
        offer(7, 3'd0);
        chk("first_accept_after_rst", 64'(acc_cyc - rel), 64'(0));
        out_ready = 1;
        repeat (10) @(negedge clk);
        drain();
        chk("final_count", 64'(count), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
